seq_alu: RTL and testbench

- Parametrised, handshaked successor to the single-cycle combinational ALU.
- Width is generic (XLEN). Keeps the existing opcode map 0-12 and adds the RV32M high-multiply and divide/remainder ops.
- Division is iterative (radix-2 restoring); all other ops complete in one registered cycle.
- Sits between decode/operand read and writeback; valid/ready on both sides lets the core stall on long ops.

---
 rtl/seq_alu.sv | 153 +++++++++++++++
 tb/tb_seq_alu.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: handshaked XLEN-bit ALU, RV32I ops 0-12 plus RV32M multiply-high; divide/remainder (16-19) only with SEQ_ALU_DIV_EN.
// Latency: 1 cycle for all ops and divide special cases; XLEN+1 cycles for a normal divide.
// Backpressure: result held in DONE until out_ready; in_ready low while dividing or while a result is stalled.
module seq_alu #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] s1,
  input  logic [XLEN-1:0] s2,
  input  logic [7:0]      alu_control,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            out_illegal
);

  localparam logic [7:0] OP_ADD = 8'd0, OP_SUB = 8'd1, OP_AND = 8'd2, OP_OR = 8'd3,
                         OP_XOR = 8'd4, OP_SLT = 8'd5, OP_SLTU = 8'd6, OP_SRA = 8'd7,
                         OP_SRL = 8'd8, OP_SLL = 8'd9, OP_MUL = 8'd10, OP_LUI = 8'd11,
                         OP_AUIPC = 8'd12, OP_MULH = 8'd13, OP_MULHSU = 8'd14, OP_MULHU = 8'd15;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic              accept;
  logic [XLEN-1:0]   op_res;
  logic              op_ill;
  logic              op_iter;
  logic [SHW-1:0]    shamt;
  logic              mul_s1_sgn, mul_s2_sgn;
  logic [2*XLEN-1:0] mul_a, mul_b, prod;

  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign accept   = in_valid && in_ready;
  assign shamt    = s2[SHW-1:0];

  // One 2*XLEN multiplier serves all four multiply ops; sign extension selects the flavour.
  assign mul_s1_sgn = (alu_control == OP_MULH || alu_control == OP_MULHSU) && s1[XLEN-1];
  assign mul_s2_sgn = (alu_control == OP_MULH) && s2[XLEN-1];
  assign mul_a      = {{XLEN{mul_s1_sgn}}, s1};
  assign mul_b      = {{XLEN{mul_s2_sgn}}, s2};
  assign prod       = mul_a * mul_b;

`ifdef SEQ_ALU_DIV_EN
  localparam logic [7:0] OP_DIV = 8'd16, OP_DIVU = 8'd17, OP_REM = 8'd18, OP_REMU = 8'd19;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef struct packed {
    logic neg_q;
    logic neg_r;
    logic want_rem;
  } div_ctx_t;

  div_ctx_t        ctx, ctx_nxt;
  logic            div_sgn, want_rem, div_zero, div_ovf;
  logic [XLEN-1:0] s1_mag, s2_mag, div_rem, div_quo, div_dsr, rem_nxt, quo_nxt;
  logic [XLEN:0]   rem_sh, trial;
  logic [SHW:0]    cnt;

  assign div_sgn  = (alu_control == OP_DIV) || (alu_control == OP_REM);
  assign want_rem = (alu_control == OP_REM) || (alu_control == OP_REMU);
  assign ctx_nxt  = '{neg_q: div_sgn && (s1[XLEN-1] ^ s2[XLEN-1]),
                      neg_r: div_sgn && s1[XLEN-1],
                      want_rem: want_rem};
  assign s1_mag   = (div_sgn && s1[XLEN-1]) ? -s1 : s1;
  assign s2_mag   = (div_sgn && s2[XLEN-1]) ? -s2 : s2;
  assign div_zero = (s2 == '0);
  assign div_ovf  = div_sgn && (s1 == MIN_NEG) && (s2 == '1);

  // Restoring step: shift the next dividend bit into the partial remainder, subtract if it fits.
  assign rem_sh  = {div_rem, div_quo[XLEN-1]};
  assign trial   = rem_sh - {1'b0, div_dsr};
  assign rem_nxt = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
  assign quo_nxt = {div_quo[XLEN-2:0], ~trial[XLEN]};
`endif

  always_comb begin
    op_res  = '0;
    op_ill  = 1'b0;
    op_iter = 1'b0;
    case (alu_control)
      OP_ADD:    op_res = s1 + s2;
      OP_SUB:    op_res = s1 - s2;
      OP_AND:    op_res = s1 & s2;
      OP_OR:     op_res = s1 | s2;
      OP_XOR:    op_res = s1 ^ s2;
      OP_SLT:    op_res = {{(XLEN-1){1'b0}}, $signed(s1) < $signed(s2)};
      OP_SLTU:   op_res = {{(XLEN-1){1'b0}}, s1 < s2};
      OP_SRA:    op_res = $signed(s1) >>> shamt;
      OP_SRL:    op_res = s1 >> shamt;
      OP_SLL:    op_res = s1 << shamt;
      OP_MUL:    op_res = prod[XLEN-1:0];
      OP_LUI:    op_res = s2 << 12;
      OP_AUIPC:  op_res = s1 + (s2 << 12);
      OP_MULH, OP_MULHSU, OP_MULHU: op_res = prod[2*XLEN-1:XLEN];
`ifdef SEQ_ALU_DIV_EN
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
        if (div_zero)     op_res = want_rem ? s1 : '1;
        else if (div_ovf) op_res = want_rem ? '0 : s1;
        else              op_iter = 1'b1;
      end
`endif
      default:   op_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      result      <= '0;
      out_illegal <= 1'b0;
    end else if (accept) begin
      out_illegal <= op_ill;
      if (op_iter) begin
        state     <= BUSY;
        out_valid <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
        div_rem   <= '0;
        div_quo   <= s1_mag;
        div_dsr   <= s2_mag;
        cnt       <= (SHW+1)'(XLEN);
        ctx       <= ctx_nxt;
`endif
      end else begin
        state     <= DONE;
        out_valid <= 1'b1;
        result    <= op_res;
      end
    end else if (state == DONE && out_ready) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end
`ifdef SEQ_ALU_DIV_EN
    else if (state == BUSY) begin
      div_rem <= rem_nxt;
      div_quo <= quo_nxt;
      cnt     <= cnt - 1'b1;
      if (cnt == 1) begin
        state     <= DONE;
        out_valid <= 1'b1;
        result    <= ctx.want_rem ? (ctx.neg_r ? -rem_nxt : rem_nxt)
                                  : (ctx.neg_q ? -quo_nxt : quo_nxt);
      end
    end
`endif
  end

endmodule

// File: tb/tb_seq_alu.sv
// Randomized self-checking bench for seq_alu (XLEN=32) against an arithmetic reference model.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] s1, s2;
  logic [7:0]  alu_control;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        out_illegal;

  int n_vec = 0;
  int n_err = 0;

  seq_alu #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .s1(s1), .s2(s2), .alu_control(alu_control), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: result, illegal flag and accept-to-out_valid latency from the opcode rules.
  function automatic void model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ill, output int lat);
    longint sa, sb, p;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r = 32'd0; ill = 1'b0; lat = 1;
    case (op)
      8'd0:  r = a + b;
      8'd1:  r = a - b;
      8'd2:  r = a & b;
      8'd3:  r = a | b;
      8'd4:  r = a ^ b;
      8'd5:  r = (sa < sb) ? 32'd1 : 32'd0;
      8'd6:  r = (ua < ub) ? 32'd1 : 32'd0;
      8'd7:  begin p = sa >>> b[4:0]; r = p[31:0]; end
      8'd8:  r = a >> b[4:0];
      8'd9:  r = a << b[4:0];
      8'd10: begin up = ua * ub; r = up[31:0]; end
      8'd11: r = b << 12;
      8'd12: r = a + (b << 12);
      8'd13: begin p = sa * sb; r = p[63:32]; end
      8'd14: begin p = sa * longint'(ub); r = p[63:32]; end
      8'd15: begin up = ua * ub; r = up[63:32]; end
`ifdef SEQ_ALU_DIV_EN
      8'd16, 8'd17, 8'd18, 8'd19: begin
        logic is_rem, is_sgn;
        is_rem = (op == 8'd18) || (op == 8'd19);
        is_sgn = (op == 8'd16) || (op == 8'd18);
        if (b == 32'd0) begin
          r = is_rem ? a : 32'hFFFF_FFFF;
        end else if (is_sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          r = is_rem ? 32'd0 : a;
        end else begin
          lat = 33;
          if (is_sgn) begin p = is_rem ? (sa % sb) : (sa / sb); r = p[31:0]; end
          else begin up = is_rem ? (ua % ub) : (ua / ub); r = up[31:0]; end
        end
      end
`endif
      default: ill = 1'b1;
    endcase
  endfunction

  // Issue one op, wait for its result (bounded), optionally stall the consumer for 'hold' cycles.
  task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, output logic [31:0] got_res, output logic got_ill);
    logic [31:0] er;
    logic        ei;
    int          elat, lat, busy, guard;
    model(op, a, b, er, ei, elat);
    alu_control = op; s1 = a; s2 = b; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    check("accept_rdy", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; s1 = $urandom; s2 = $urandom; alu_control = 8'($urandom);
    lat = 1; busy = 0;
    while (!out_valid && lat < 100) begin
      if (!in_ready) busy++;
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, elat);
    check("busy_cycles", busy, elat - 1);
    check("result", result, er);
    check("illegal", {31'd0, out_illegal}, {31'd0, ei});
    got_res = result;
    got_ill = out_illegal;
    if (hold > 0) begin
      out_ready = 1'b0;
      repeat (hold) begin
        @(posedge clk); #1;
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_result", result, er);
        check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("drain_valid", {31'd0, out_valid}, 32'd0);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] r;
    logic        il;
    logic [7:0]  op;
    int          seen;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    s1 = '0; s2 = '0; alu_control = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_illegal", {31'd0, out_illegal}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    run_op(8'd0, 32'hFFFF_FFFF, 32'd1, 0, r, il);
    check("tp_add_wrap", r, 32'd0);
    run_op(8'd0, 32'd5, 32'd6, 0, r, il);
    check("tp_add_b2b", r, 32'd11);
    run_op(8'd7, 32'h8000_0000, 32'h24, 0, r, il);
    check("tp_sra", r, 32'hF800_0000);
    run_op(8'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, r, il);
    check("tp_mulhu", r, 32'hFFFF_FFFE);
    run_op(8'd13, 32'hFFFF_FFFE, 32'd3, 0, r, il);
    check("tp_mulh", r, 32'hFFFF_FFFF);
    run_op(8'd200, 32'd1, 32'd2, 2, r, il);
    check("tp_ill_res", r, 32'd0);
    check("tp_ill_flag", {31'd0, il}, 32'd1);
    run_op(8'd1, 32'd10, 32'd3, 3, r, il);
    check("tp_sub_hold", r, 32'd7);

`ifdef SEQ_ALU_DIV_EN
    run_op(8'd16, 32'hFFFF_FFF9, 32'd2, 0, r, il);
    check("tp_div", r, 32'hFFFF_FFFD);
    run_op(8'd18, 32'hFFFF_FFF9, 32'd2, 0, r, il);
    check("tp_rem", r, 32'hFFFF_FFFF);
    run_op(8'd17, 32'd5, 32'd0, 0, r, il);
    check("tp_divu_zero", r, 32'hFFFF_FFFF);
    run_op(8'd16, 32'h8000_0000, 32'hFFFF_FFFF, 0, r, il);
    check("tp_div_ovf", r, 32'h8000_0000);
    run_op(8'd18, 32'h8000_0000, 32'hFFFF_FFFF, 0, r, il);
    check("tp_rem_ovf", r, 32'd0);
    run_op(8'd17, 32'd100, 32'd7, 5, r, il);
    check("tp_divu_hold", r, 32'd14);

    // Reset in the middle of a divide must discard it entirely.
    s1 = 32'd100; s2 = 32'd7; alu_control = 8'd16; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mid_busy_rdy", {31'd0, in_ready}, 32'd0);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_rdy", {31'd0, in_ready}, 32'd1);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
    check("mid_rst_stale", seen, 0);
`else
    run_op(8'd16, 32'd100, 32'd7, 0, r, il);
    check("tp_div_off_res", r, 32'd0);
    check("tp_div_off_ill", {31'd0, il}, 32'd1);
`endif

    for (int i = 0; i < 400; i++) begin
      op = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(20, 255)) : 8'($urandom_range(0, 19));
      run_op(op, pick(), pick(), ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0, r, il);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
